// File: rtl/op_stack.sv
// Operand stack with push/pop/dup/swap, split half-word push, and sticky error flags.
// Top entry lives in a register; the remaining DEPTH-1 entries sit in an array below it.
module op_stack #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ce,
    input  logic                           cmd_valid,
    input  logic [2:0]                     cmd_op,
    input  logic [DATA_WIDTH-1:0]          cmd_data,
    output logic                           cmd_ready,
    output logic [DATA_WIDTH-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full,
    output logic                           err_overflow,
    output logic                           err_underflow,
    input  logic                           err_clear
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = DATA_WIDTH / 2;

    typedef enum logic {
        IDLE,
        HALF
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_PUSH_LO = 3'd5,
        OP_PUSH_HI = 3'd6,
        OP_CLEAR   = 3'd7
    } op_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   top_q, top_d;
    logic [HW-1:0]           lo_q, lo_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic [DATA_WIDTH-1:0]   below [DEPTH-1];
    logic [DATA_WIDTH-1:0]   second;
    logic                    wr_en;
    logic [CW-1:0]           wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic                    accept;
    op_e                     op;
    logic                    push_en;
    logic [DATA_WIDTH-1:0]   push_val;
    logic [HW-1:0]           lo_src;
    logic                    new_ovf;
    logic                    new_unf;

    assign cmd_ready     = ce & reset_n;
    assign accept        = cmd_valid & cmd_ready;
    assign op            = op_e'(cmd_op);

    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign top           = empty ? '0 : top_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

    // Entry directly beneath the top register; only meaningful when count >= 2.
    always_comb begin
        second = '0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (CW'(i) == count_q - CW'(2)) begin
                second = below[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        top_d    = top_q;
        lo_d     = lo_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_en    = 1'b0;
        wr_idx   = count_q - CW'(1);
        wr_data  = top_q;
        push_en  = 1'b0;
        push_val = '0;
        lo_src   = '0;
        new_ovf  = 1'b0;
        new_unf  = 1'b0;

        if (state_q == HALF) begin
            lo_src = lo_q;
        end

        if (accept) begin
            case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    state_d  = IDLE;
                    push_en  = 1'b1;
                    push_val = cmd_data;
                end
                OP_POP: begin
                    state_d = IDLE;
                    if (empty) begin
                        new_unf = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                        top_d   = second;
                    end
                end
                OP_DUP: begin
                    state_d = IDLE;
                    if (empty) begin
                        new_unf = 1'b1;
                    end else begin
                        push_en  = 1'b1;
                        push_val = top_q;
                    end
                end
                OP_SWAP: begin
                    state_d = IDLE;
                    if (count_q < CW'(2)) begin
                        new_unf = 1'b1;
                    end else begin
                        top_d   = second;
                        wr_en   = 1'b1;
                        wr_idx  = count_q - CW'(2);
                        wr_data = top_q;
                    end
                end
                OP_PUSH_LO: begin
                    state_d = HALF;
                    lo_d    = cmd_data[HW-1:0];
                end
                OP_PUSH_HI: begin
                    state_d  = IDLE;
                    push_en  = 1'b1;
                    push_val = {cmd_data[HW-1:0], lo_src};
                end
                OP_CLEAR: begin
                    state_d = IDLE;
                    count_d = '0;
                end
                default: ;
            endcase

            // The old top sinks into the array only if there was one to begin with.
            if (push_en) begin
                if (full) begin
                    new_ovf = 1'b1;
                end else begin
                    top_d   = push_val;
                    count_d = count_q + CW'(1);
                    if (!empty) begin
                        wr_en   = 1'b1;
                        wr_idx  = count_q - CW'(1);
                        wr_data = top_q;
                    end
                end
            end
        end

        if (ce) begin
            ovf_d = (ovf_q & ~err_clear) | new_ovf;
            unf_d = (unf_q & ~err_clear) | new_unf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            top_q   <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            top_q   <= top_d;
            lo_q    <= lo_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (CW'(i) == wr_idx) begin
                    below[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_op_stack.sv
// Self-checking bench for op_stack: queue-based reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_op_stack;

    localparam int W  = 12;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    localparam int NOP = 0, PUSH = 1, POP = 2, DUP = 3, SWAP = 4, PLO = 5, PHI = 6, CLR = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ce = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_ready;
    logic [W-1:0]  top;
    logic [CW-1:0] count;
    logic          empty, full, err_overflow, err_underflow;
    logic          err_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model: queue back is the top of stack.
    logic [W-1:0] mq[$];
    bit           m_half;
    logic [5:0]   m_lo;
    bit           m_ovf, m_unf;

    op_stack #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .top           (top),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_clear     (err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_half = 1'b0;
        m_lo   = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    function automatic logic [31:0] m_top();
        if (mq.size() == 0) return 0;
        return 32'(mq[$]);
    endfunction

    task automatic model_step();
        bit           eo, eu, dp;
        logic [W-1:0] pv, a, b;
        eo = 1'b0; eu = 1'b0; dp = 1'b0; pv = '0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!ce) return;
        if (cmd_valid) begin
            case (int'(cmd_op))
                PUSH: begin dp = 1'b1; pv = cmd_data; m_half = 1'b0; end
                POP: begin
                    m_half = 1'b0;
                    if (mq.size() == 0) eu = 1'b1;
                    else void'(mq.pop_back());
                end
                DUP: begin
                    m_half = 1'b0;
                    if (mq.size() == 0) eu = 1'b1;
                    else begin dp = 1'b1; pv = mq[$]; end
                end
                SWAP: begin
                    m_half = 1'b0;
                    if (mq.size() < 2) eu = 1'b1;
                    else begin
                        a = mq.pop_back();
                        b = mq.pop_back();
                        mq.push_back(a);
                        mq.push_back(b);
                    end
                end
                PLO: begin m_lo = cmd_data[5:0]; m_half = 1'b1; end
                PHI: begin
                    dp = 1'b1;
                    pv = {cmd_data[5:0], m_half ? m_lo : 6'h00};
                    m_half = 1'b0;
                end
                CLR: begin mq.delete(); m_half = 1'b0; end
                default: ;
            endcase
            if (dp) begin
                if (mq.size() == D) eo = 1'b1;
                else mq.push_back(pv);
            end
        end
        if (err_clear) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (eo) m_ovf = 1'b1;
        if (eu) m_unf = 1'b1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_top",   top,           m_top());
            chk("cmp_count", count,         mq.size());
            chk("cmp_empty", empty,         mq.size() == 0);
            chk("cmp_full",  full,          mq.size() == D);
            chk("cmp_ovf",   err_overflow,  m_ovf);
            chk("cmp_unf",   err_underflow, m_unf);
            chk("cmp_ready", cmd_ready,     ce && reset_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmd(input int op, input int data, input bit clr = 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = W'(data);
        err_clear = clr;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        err_clear = 1'b0;
    endtask

    task automatic idle_clr();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        reset_n = 1'b0;
        model_reset();
        started = 1'b1;
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_top",   top, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_flags", {err_overflow, err_underflow}, 0);
        reset_n = 1'b1;
        #1;
        chk("ready_up", cmd_ready, 1);

        // push/swap/pop
        cmd(PUSH, 'h123); chk("p1_top", top, 'h123);
        cmd(PUSH, 'h456); chk("p2_top", top, 'h456);
        cmd(SWAP, 0);     chk("swap_top", top, 'h123); chk("swap_count", count, 2);
        cmd(POP, 0);      chk("pop_top", top, 'h456);  chk("pop_count", count, 1);
        cmd(CLR, 0);      chk("clr_count", count, 0);

        // overflow
        for (int i = 1; i <= 5; i++) cmd(PUSH, i);
        chk("ovf_count", count, 4); chk("ovf_full", full, 1);
        chk("ovf_top", top, 'h004); chk("ovf_flag", err_overflow, 1);
        idle_clr(); chk("ovf_clr", err_overflow, 0);
        cmd(DUP, 0);
        chk("dup_ovf", err_overflow, 1); chk("dup_count", count, 4); chk("dup_top", top, 'h004);
        idle_clr();
        cmd(CLR, 0);

        // underflow
        cmd(POP, 0);  chk("unf_pop", err_underflow, 1); chk("unf_pop_count", count, 0);
        idle_clr();   chk("unf_clr", err_underflow, 0);
        cmd(PUSH, 'h0AA);
        cmd(SWAP, 0); chk("unf_swap", err_underflow, 1); chk("unf_swap_count", count, 1);
        chk("unf_swap_top", top, 'h0AA);
        idle_clr();
        cmd(POP, 0);  chk("pop_ok_flag", err_underflow, 0); chk("pop_ok_count", count, 0);
        cmd(POP, 0, 1'b1); chk("clr_vs_new", err_underflow, 1);
        idle_clr();

        // half-word pushes
        cmd(PLO, 'h02A); chk("plo_nochange", count, 0);
        cmd(PHI, 'h015); chk("phi_top", top, 'h56A); chk("phi_count", count, 1);
        cmd(PLO, 'h011); cmd(POP, 0); chk("half_drop_count", count, 0);
        cmd(PHI, 'h03F); chk("phi_idle_top", top, 'hFC0);
        cmd(PLO, 'h005); cmd(NOP, 0); cmd(PHI, 'h001); chk("nop_keeps_half", top, 'h045);
        cmd(PLO, 'h03F); cmd(PLO, 'h002); cmd(PHI, 'h002); chk("plo_overwrite", top, 'h082);
        cmd(PUSH, 'h111); chk("fill_count", count, 4);
        cmd(PLO, 'h001); cmd(PHI, 'h001);
        chk("phi_ovf", err_overflow, 1); chk("phi_ovf_top", top, 'h111);
        cmd(POP, 0); chk("pop_after_ovf", top, 'h082);
        cmd(PHI, 'h002); chk("phi_back_idle", top, 'h080); chk("phi_back_count", count, 4);
        idle_clr();
        cmd(CLR, 0);

        // clock enable and reset in HALF
        cmd(POP, 0);
        ce = 1'b0; cmd_valid = 1'b1; cmd_op = 3'(PUSH); cmd_data = 'h7FF; err_clear = 1'b1;
        #1;
        chk("ce0_ready", cmd_ready, 0);
        tick();
        chk("ce0_count", count, 0); chk("ce0_top", top, 0); chk("ce0_flag_kept", err_underflow, 1);
        ce = 1'b1; cmd_valid = 1'b0; err_clear = 1'b0;
        idle_clr();
        cmd(PLO, 'h001);
        reset_pulse();
        cmd(PHI, 'h001); chk("rst_half_count", count, 1); chk("rst_half_top", top, 'h040);

        // randomised traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            ce        = ($urandom_range(0, 9) != 0);
            err_clear = ($urandom_range(0, 9) == 0);
            cmd_valid = ($urandom_range(0, 4) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            if (cmd_op == 3'(CLR) && $urandom_range(0, 3) != 0) cmd_op = 3'(PUSH);
            cmd_data  = W'($urandom);
            if (i == 200) reset_pulse();
            tick();
        end
        ce = 1'b1; cmd_valid = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
